fp_issue_ctrl: RTL

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

---
 rtl/fp_issue_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp_issue_ctrl
//  Description : Floating-point issue controller. It holds the FP register
//                file, a pending-write scoreboard and a one-entry issue stage,
//                and tracks the number of in-flight FPU operations.
//                Writebacks come from FPU results or from FP loads.
//  Config      : define FP_ISSUE_BYPASS_EN to let a request whose source is
//                being written back in the same cycle take that operand
//                directly from fpu_result_i.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_issue_ctrl #(
    parameter  int DATAWIDTH = 32,
    parameter  int NUM_REGS  = 32,
    parameter  int DEPTH     = 4,
    parameter  int OP_W      = 16,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int TW        = AW + 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AW-1:0]          req_rs1_i,
    input  logic [AW-1:0]          req_rs2_i,
    input  logic [AW-1:0]          req_rs3_i,
    input  logic [2:0]             req_use_i,
    input  logic [AW-1:0]          req_rd_i,
    input  logic                   req_wb_i,
    input  logic [OP_W-1:0]        req_op_i,
    output logic                   fpu_valid_o,
    input  logic                   fpu_ready_i,
    output logic [3*DATAWIDTH-1:0] fpu_operands_o,
    output logic [OP_W-1:0]        fpu_op_o,
    output logic [TW-1:0]          fpu_tag_o,
    input  logic                   fpu_out_valid_i,
    output logic                   fpu_out_ready_o,
    input  logic [DATAWIDTH-1:0]   fpu_result_i,
    input  logic [TW-1:0]          fpu_tag_i,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    input  logic [AW-1:0]          ld_addr_i,
    input  logic [DATAWIDTH-1:0]   ld_data_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic [CW-1:0]          outstanding_o
);

`ifdef FP_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATAWIDTH-1:0]   rf_q [NUM_REGS];
    logic [NUM_REGS-1:0]    pend_q, pend_d;
    logic                   stage_valid_q;
    logic [3*DATAWIDTH-1:0] stage_opnd_q;
    logic [OP_W-1:0]        stage_op_q;
    logic [TW-1:0]          stage_tag_q;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   fpu_fire;
    logic                   res_fire;
    logic                   res_wr;
    logic [AW-1:0]          res_rd;
    logic                   accept;
    logic                   ld_fire;
    logic                   flush_kill;
    logic                   rd_blk;
    logic                   cnt_ok;
    logic [2:0]             src_blk;
    logic [AW-1:0]          rs_addr [3];
    logic [DATAWIDTH-1:0]   opnd    [3];

    assign fpu_fire   = stage_valid_q & fpu_ready_i;
    assign res_fire   = fpu_out_valid_i;           // result port is always ready
    assign res_wr     = res_fire & fpu_tag_i[AW];
    assign res_rd     = fpu_tag_i[AW-1:0];
    // An FPU handshake in the same cycle takes priority over a flush.
    assign flush_kill = flush_i & stage_valid_q & ~fpu_fire;
    assign rd_blk     = req_wb_i & pend_q[req_rd_i];
    assign cnt_ok     = cnt_q < CW'(DEPTH);

    assign rs_addr[0] = req_rs1_i;
    assign rs_addr[1] = req_rs2_i;
    assign rs_addr[2] = req_rs3_i;

    // Per-source hazard detection and operand selection (bypass only when enabled).
    for (genvar k = 0; k < 3; k++) begin : g_src
        logic byp_hit;
        assign byp_hit    = BYPASS && res_wr && (res_rd == rs_addr[k]);
        assign src_blk[k] = req_use_i[k] && pend_q[rs_addr[k]] && !byp_hit;
        assign opnd[k]    = byp_hit ? fpu_result_i : rf_q[rs_addr[k]];
    end

    // Ready is forced low while in reset so nothing is seen as accepted.
    assign req_ready_o = rst_ni & (~stage_valid_q | fpu_fire) & ~(|src_blk) & ~rd_blk
                       & cnt_ok & ~ld_valid_i & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;

    // FPU results own the write port; loads wait out any result cycle.
    assign ld_ready_o  = ~fpu_out_valid_i & ~pend_q[ld_addr_i];
    assign ld_fire     = ld_valid_i & ld_ready_o;

    assign fpu_valid_o     = stage_valid_q;
    assign fpu_operands_o  = stage_opnd_q;
    assign fpu_op_o        = stage_op_q;
    assign fpu_tag_o       = stage_tag_q;
    assign fpu_out_ready_o = 1'b1;
    assign outstanding_o   = cnt_q;
    assign busy_o          = stage_valid_q | (cnt_q != '0);

    // Scoreboard next state: clears from writeback/flush, set from a new issue.
    always_comb begin
        pend_d = pend_q;
        if (res_wr) begin
            pend_d[res_rd] = 1'b0;
        end
        if (flush_kill && stage_tag_q[AW]) begin
            pend_d[stage_tag_q[AW-1:0]] = 1'b0;
        end
        if (accept && req_wb_i) begin
            pend_d[req_rd_i] = 1'b1;
        end
    end

    // In-flight count: +1 per accept, -1 per result, -1 per flushed stage entry.
    always_comb begin
        cnt_d = cnt_q + CW'(accept) - CW'(res_fire) - CW'(flush_kill);
    end

    // Register file write port (FPU result has priority over load).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (res_wr) begin
            rf_q[res_rd] <= fpu_result_i;
        end else if (ld_fire) begin
            rf_q[ld_addr_i] <= ld_data_i;
        end
    end

    // Issue stage: capture on accept, release on FPU handshake or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_q <= 1'b0;
            stage_opnd_q  <= '0;
            stage_op_q    <= '0;
            stage_tag_q   <= '0;
        end else if (accept) begin
            stage_valid_q <= 1'b1;
            stage_opnd_q  <= {opnd[2], opnd[1], opnd[0]};
            stage_op_q    <= req_op_i;
            stage_tag_q   <= {req_wb_i, req_rd_i};
        end else if (fpu_fire || flush_kill) begin
            stage_valid_q <= 1'b0;
        end
    end

    // Scoreboard and outstanding counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire
